// File: rtl/cla_add_sequencer.sv
// Round-robin sequencer that shares one external 8-bit carry-lookahead adder between two requesters.
// Optional signed-overflow flag on the response is built when CLA_SEQ_OVF_EN is defined.
module cla_add_sequencer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic [WIDTH-1:0] cla_a,
    output logic [WIDTH-1:0] cla_b,
    output logic             cla_cin,
    input  logic [WIDTH-1:0] cla_sum,
    input  logic             cla_cout,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    // Counter reload: the capture edge is the one that sees cnt == 0.
    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] cla_a_q, cla_a_d;
    logic [WIDTH-1:0] cla_b_q, cla_b_d;
    logic             cla_cin_q, cla_cin_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic             grant;
    logic             grant_valid;
    logic             accept;
    logic             capture;

    // Arbitration: a lone requester wins outright; on a tie the one not granted last time wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~req0_valid;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign accept     = rst_n && (state_q == StIdle) && grant_valid;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign capture    = (state_q == StSettle) && (cnt_q == 4'd0);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        cla_a_d      = cla_a_q;
        cla_b_d      = cla_b_q;
        cla_cin_d    = cla_cin_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cla_a_d      = grant ? req1_a : req0_a;
                    cla_b_d      = grant ? req1_b : req0_b;
                    cla_cin_d    = grant ? req1_cin : req0_cin;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = CntInit;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (capture) begin
                    rsp_sum_d   = cla_sum;
                    rsp_cout_d  = cla_cout;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            cla_a_q      <= '0;
            cla_b_q      <= '0;
            cla_cin_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            cla_a_q      <= cla_a_d;
            cla_b_q      <= cla_b_d;
            cla_cin_q    <= cla_cin_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

`ifdef CLA_SEQ_OVF_EN
    logic rsp_ovf_q, rsp_ovf_d;

    // Signed overflow: like-signed operands producing a sum of the opposite sign.
    always_comb begin
        rsp_ovf_d = rsp_ovf_q;
        if (capture) begin
            rsp_ovf_d = (cla_a_q[WIDTH-1] == cla_b_q[WIDTH-1]) &&
                        (cla_sum[WIDTH-1] != cla_a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf_q <= 1'b0;
        end else begin
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign cla_a     = cla_a_q;
    assign cla_b     = cla_b_q;
    assign cla_cin   = cla_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer: the bench models the external adder, and a scoreboard
// holds expected responses queued when requests are driven.
module tb_cla_add_sequencer;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] cla_a, cla_b, cla_sum;
    logic         cla_cin, cla_cout;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
    logic [W-1:0] rsp_sum;

    always #5 clk = ~clk;

    cla_add_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .cla_a      (cla_a),
        .cla_b      (cla_b),
        .cla_cin    (cla_cin),
        .cla_sum    (cla_sum),
        .cla_cout   (cla_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    // External adder datapath
    assign {cla_cout, cla_sum} = 9'(cla_a) + 9'(cla_b) + 9'(cla_cin);

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t bp_e;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   k;

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.id   = id;
        e.sum  = full[W-1:0];
        e.cout = full[W];
`ifdef CLA_SEQ_OVF_EN
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, cla_a, cla_b, cla_cin,
                    req0_ready, req1_ready}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (rsp_valid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    // Single request from an idle sequencer with rsp_ready already high.
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        int lat;
        drive(id, a, b, cin);
        #1;
        check("ready_granted", id ? req1_ready : req0_ready, 1);
        check("ready_other", id ? req0_ready : req1_ready, 0);
        sb.push_back(model(id, a, b, cin));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("cla_operands", {cla_a, cla_b, cla_cin}, {a, b, cin});
        wait_rsp(lat);
        check("latency", lat, S);
        tick();
        check("idle_after_rsp", {busy, rsp_valid}, 0);
    endtask

    // Both requesters valid from an idle state whose last grant was requester 1.
    task automatic tie_run(input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1);
        int lat;
        int gap;
        drive(0, a0, b0, 1'b0);
        drive(1, a1, b1, 1'b0);
        #1;
        check("tie_req0_ready", req0_ready, 1);
        check("tie_req1_ready", req1_ready, 0);
        sb.push_back(model(0, a0, b0, 1'b0));
        sb.push_back(model(1, a1, b1, 1'b0));
        tick();
        req0_valid = 1'b0;
        check("tie_req1_blocked", req1_ready, 0);
        gap = 0;
        while (req1_ready !== 1'b1 && gap < 20) begin
            tick();
            gap++;
        end
        check("accept_gap", gap + 1, S + 2);
        tick();
        req1_valid = 1'b0;
        check("tie_second_id", {busy, rsp_id}, {1'b1, 1'b1});
        wait_rsp(lat);
        check("tie_latency", lat, S);
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", rsp_id, mon_e.id);
                check("rsp_sum", rsp_sum, mon_e.sum);
                check("rsp_cout", rsp_cout, mon_e.cout);
                check("rsp_ovf", rsp_ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        #2;
        check_all_zero("reset_outputs");
        req0_valid = 1'b1;
        #1;
        check("ready_in_reset", req0_ready, 0);
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // Single op and wrap-around
        do_op(0, 8'h35, 8'h4A, 1'b0);
        do_op(1, 8'hFF, 8'h01, 1'b1);

        // Tie straight out of reset
        rst_n = 1'b0;
        drive(0, 8'h10, 8'h20, 1'b0);
        drive(1, 8'h01, 8'h02, 1'b0);
        #1;
        check_all_zero("tie_in_reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tie_run(8'h10, 8'h20, 8'h01, 8'h02);

        // Backpressure with a competing request pending
        rsp_ready = 1'b0;
        drive(0, 8'h55, 8'h22, 1'b0);
        bp_e = model(0, 8'h55, 8'h22, 1'b0);
        sb.push_back(bp_e);
        #1;
        check("bp_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        wait_rsp(n);
        check("bp_latency", n, S);
        drive(1, 8'h80, 8'h80, 1'b0);
        sb.push_back(model(1, 8'h80, 8'h80, 1'b0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_hold", {rsp_valid, rsp_id, rsp_sum, rsp_cout}, {1'b1, bp_e.id, bp_e.sum,
                  bp_e.cout});
            check("bp_ready_low", {req0_ready, req1_ready}, 0);
            check("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_idle", {busy, rsp_valid}, 0);
        check("bp_next_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        wait_rsp(n);
        check("bp2_latency", n, S);
        tick();

        // Reset one cycle after accept discards the transaction
        drive(0, 8'hAA, 8'h11, 1'b0);
        tick();
        req0_valid = 1'b0;
        check("pre_reset_busy", busy, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_settle");
        tick();
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0) k++;
        end
        check("no_rsp_after_reset", k, 0);
        tie_run(8'h03, 8'h04, 8'h05, 8'h06);

        // Signed overflow
        do_op(0, 8'h7F, 8'h01, 1'b0);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_add_sequencer.md
Name: cla_add_sequencer

Overview:
Sequencer and arbiter in front of the 8-bit carry-lookahead adder datapath. Two requesters share the single adder. A round-robin arbiter grants one request at a time. The block registers the granted operands onto the adder inputs and holds them for a programmable settle window, which covers the gate-delay chain through the carry logic. It then captures sum/carry and returns them with a valid/ready response.

Parameters:
WIDTH, 8, operand/sum width; the adder datapath is fixed at 8.
SETTLE_CYCLES, 3, clock edges between operand launch and result capture; legal range 1..15.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has an operation pending.
req0_ready  output  1  requester 0 accepted this cycle.
req0_a  input  WIDTH  requester 0 operand A.
req0_b  input  WIDTH  requester 0 operand B.
req0_cin  input  1  requester 0 carry-in.
req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
cla_a  output  WIDTH  registered operand A to the adder.
cla_b  output  WIDTH  registered operand B to the adder.
cla_cin  output  1  registered carry-in to the adder.
cla_sum  input  WIDTH  adder sum.
cla_cout  input  1  adder carry-out.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts result.
rsp_id  output  1  requester index of the result.
rsp_sum  output  WIDTH  captured sum.
rsp_cout  output  1  captured carry-out.
rsp_ovf  output  1  signed overflow (see Optional Feature).
busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE, last_grant=1, so req0 wins the first tie.
  - All outputs 0: cla_*, rsp_*, busy, both ready signals.
- FSM states:
  - IDLE: grant logic active.
  - SETTLE: count down.
  - RESP: hold result.
- Arbitration (IDLE only):
  - Only one valid: grant that requester.
  - Both valid: grant the one not in last_grant.
  - reqN_ready=1 combinationally for the granted requester only; ready is 0 in every other state.
- Accept (IDLE, handshake edge):
  - cla_a/cla_b/cla_cin <= granted operands.
  - rsp_id <= grant; last_grant <= grant.
  - cnt <= SETTLE_CYCLES-1; state -> SETTLE.
- SETTLE:
  - cla_* held stable.
  - cnt decrements each edge.
  - On the edge where cnt==0: rsp_sum<=cla_sum, rsp_cout<=cla_cout, rsp_valid<=1, state -> RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- RESP:
  - rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid<=0, state -> IDLE.
- Throughput: no overlap; back-to-back period is SETTLE_CYCLES+2 cycles when rsp_ready is held high.
- cla_* and rsp_sum/rsp_cout/rsp_id retain their last values in IDLE.
- Requesters hold valid and operands until ready. Dropping valid before grant is legal and cancels the request.
- Arithmetic is modulo 2^WIDTH. Carry-out comes only from cla_cout; the block performs no addition itself.
- Reset mid-SETTLE or mid-RESP: the transaction is discarded, all outputs are 0 immediately, and no response is issued.

Optional Feature:
Macro: CLA_SEQ_OVF_EN.
- Defined: at capture, rsp_ovf <= (cla_a[MSB]==cla_b[MSB]) && (cla_sum[MSB]!=cla_a[MSB]). Held with rsp_sum.
- Undefined: rsp_ovf is tied 0 and no overflow logic is built. The port exists in both builds.

Test Plan:
- Single op, SETTLE_CYCLES=3. Stimulus: req0 a=0x35, b=0x4A, cin=0. Response:
  - req0_ready high in IDLE.
  - rsp_valid 3 edges after accept.
  - rsp_sum=0x7F, rsp_cout=0, rsp_id=0.
- Wrap-around. Stimulus: req1 a=0xFF, b=0x01, cin=1. Response: rsp_sum=0x01, rsp_cout=1, rsp_id=1.
- Tie and round-robin. Stimulus: both valid from reset (req0 0x10+0x20, req1 0x01+0x02), rsp_ready=1. Response:
  - Responses are id0/0x30, then id1/0x03.
  - Accept edges are 5 cycles apart.
- Backpressure. Stimulus: rsp_ready=0 for 6 cycles after rsp_valid. Response:
  - rsp_* unchanged.
  - Both ready signals 0, busy=1.
  - IDLE one edge after rsp_ready=1.
- Reset mid-SETTLE. Stimulus: pull rst_n low 1 cycle after accept. Response:
  - All outputs 0 at once, no rsp_valid.
  - Next req0 tie still favours req0.
- Overflow. Stimulus: 0x7F+0x01, cin=0. Response:
  - With CLA_SEQ_OVF_EN: rsp_ovf=1, rsp_sum=0x80.
  - Without: rsp_ovf=0.
